controle_jogo_param: RTL and testbench

- Parametrised game-control FSM for the sequence-memory game, with its round, play and timeout counters built in.
- Adds configurable sequence length, per-play timeout, initial-display time and number of lives.
- Adds a mode input: fixed stored sequence, or player-extended sequence written to RAM.
- Drives the RAM address and write, the jogada register load and the status LEDs; the comparator result comes from the datapath.

---
 rtl/controle_jogo_if.sv | 32 +++
 rtl/controle_jogo_param.sv | 171 +++++++++++++++++
 tb/tb_controle_jogo_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/controle_jogo_if.sv
// Bus between the sequence-memory game controller and its datapath/panel.
// The master side drives the player inputs; the slave side is the controller.
interface controle_jogo_if #(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              jogada;
    logic              jogada_correta;
    logic              modo;
    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] rodada;
    logic              registraR;
    logic              gravaRAM;
    logic              exibe_jogada_inicial;
    logic [2:0]        vidas_restantes;
    logic              pronto;
    logic              acertou;
    logic              errou;
    logic [3:0]        db_estado;

    modport master (
        output iniciar, jogada, jogada_correta, modo,
        input  endereco, rodada, registraR, gravaRAM, exibe_jogada_inicial,
               vidas_restantes, pronto, acertou, errou, db_estado
    );

    modport slave (
        input  iniciar, jogada, jogada_correta, modo,
        output endereco, rodada, registraR, gravaRAM, exibe_jogada_inicial,
               vidas_restantes, pronto, acertou, errou, db_estado
    );
endinterface

// File: rtl/controle_jogo_param.sv
// Parametrised control FSM for the sequence-memory game, with the round,
// play-index and play-timeout counters kept alongside the state register.
module controle_jogo_param #(
    parameter int N_RODADAS      = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int T_INICIAL      = 2000,
    parameter int VIDAS          = 1
) (
    input logic             clock,
    input logic             reset,
    controle_jogo_if.slave  bus
);
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESPERA        = 4'h1,
        INICIO_RODADA = 4'h2,
        PREPARACAO    = 4'h3,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROX_JOGADA   = 4'h6,
        ULTIMA_JOGADA = 4'h7,
        PROX_RODADA   = 4'h8,
        ESPERA_GRAVA  = 4'h9,
        PERDE_VIDA    = 4'hA,
        TOUT          = 4'hB,
        GRAVA         = 4'hC,
        VITORIA       = 4'hD,
        DERROTA       = 4'hE
    } state_t;

    localparam int T_MAX = (TIMEOUT_CICLOS > T_INICIAL) ? TIMEOUT_CICLOS : T_INICIAL;
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]     T_INI_LAST = TW'(T_INICIAL - 1);
    localparam logic [TW-1:0]     T_OUT_LAST = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(N_RODADAS - 1);
    localparam logic [2:0]        VIDAS_INI  = 3'(VIDAS);

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [ADDR_W-1:0] endereco_reg, endereco_next;
    logic [ADDR_W-1:0] rodada_reg, rodada_next;
    logic [2:0]        vidas_reg, vidas_next;
    logic              modo_reg, modo_next;
    logic              tout_reg, tout_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= INICIAL;
            timer_reg    <= '0;
            endereco_reg <= '0;
            rodada_reg   <= '0;
            vidas_reg    <= VIDAS_INI;
            modo_reg     <= 1'b0;
            tout_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            endereco_reg <= endereco_next;
            rodada_reg   <= rodada_next;
            vidas_reg    <= vidas_next;
            modo_reg     <= modo_next;
            tout_reg     <= tout_next;
        end
    end

    // Timer defaults to zero so it is cleared in every non-counting state.
    always_comb begin
        state_next    = state_reg;
        timer_next    = '0;
        endereco_next = endereco_reg;
        rodada_next   = rodada_reg;
        vidas_next    = vidas_reg;
        modo_next     = modo_reg;
        tout_next     = tout_reg;

        case (state_reg)
            INICIAL, DERROTA, VITORIA, TOUT: begin
                if (bus.iniciar) begin
                    state_next    = PREPARACAO;
                    modo_next     = bus.modo;
                    vidas_next    = VIDAS_INI;
                    rodada_next   = '0;
                    endereco_next = '0;
                    tout_next     = 1'b0;
                end
            end
            PREPARACAO: begin
                if (timer_reg == T_INI_LAST) state_next = INICIO_RODADA;
                else                         timer_next = timer_reg + TW'(1);
            end
            INICIO_RODADA: begin
                endereco_next = '0;
                state_next    = ESPERA;
            end
            ESPERA: begin
                if (timer_reg == T_OUT_LAST) begin
                    state_next = PERDE_VIDA;
                    tout_next  = 1'b1;
                end else if (bus.jogada) begin
                    state_next = REGISTRA;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            REGISTRA: state_next = COMPARACAO;
            COMPARACAO: begin
                if (!bus.jogada_correta) begin
                    state_next = PERDE_VIDA;
                    tout_next  = 1'b0;
                end else if (endereco_reg == rodada_reg) begin
                    state_next = ULTIMA_JOGADA;
                end else begin
                    state_next = PROX_JOGADA;
                end
            end
            PROX_JOGADA: begin
                if (endereco_reg != IDX_LAST) endereco_next = endereco_reg + ADDR_W'(1);
                state_next = ESPERA;
            end
            ULTIMA_JOGADA: begin
                if (rodada_reg == IDX_LAST) state_next = VITORIA;
                else                        state_next = PROX_RODADA;
            end
            PROX_RODADA: begin
                if (rodada_reg != IDX_LAST)   rodada_next   = rodada_reg + ADDR_W'(1);
                if (endereco_reg != IDX_LAST) endereco_next = endereco_reg + ADDR_W'(1);
                state_next = modo_reg ? ESPERA_GRAVA : INICIO_RODADA;
            end
            ESPERA_GRAVA: begin
                if (timer_reg == T_OUT_LAST) begin
                    state_next = PERDE_VIDA;
                    tout_next  = 1'b1;
                end else if (bus.jogada) begin
                    state_next = GRAVA;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            GRAVA: state_next = INICIO_RODADA;
            PERDE_VIDA: begin
                if (vidas_reg != 3'd0) vidas_next = vidas_reg - 3'd1;
                // Last life gone: the cause recorded on entry picks the terminal state.
                if (vidas_reg <= 3'd1) state_next = tout_reg ? TOUT : DERROTA;
                else                   state_next = INICIO_RODADA;
            end
            default: state_next = INICIAL;
        endcase
    end

    always_comb begin
        bus.db_estado = 4'hF;
        case (state_reg)
            INICIAL, ESPERA, INICIO_RODADA, PREPARACAO, REGISTRA, COMPARACAO,
            PROX_JOGADA, ULTIMA_JOGADA, PROX_RODADA, ESPERA_GRAVA, PERDE_VIDA,
            TOUT, GRAVA, VITORIA, DERROTA: bus.db_estado = state_reg;
            default:                       bus.db_estado = 4'hF;
        endcase
    end

    assign bus.endereco             = endereco_reg;
    assign bus.rodada               = rodada_reg;
    assign bus.vidas_restantes      = vidas_reg;
    assign bus.registraR            = (state_reg == REGISTRA);
    assign bus.gravaRAM             = (state_reg == GRAVA);
    assign bus.exibe_jogada_inicial = (state_reg == PREPARACAO);
    assign bus.pronto               = (state_reg == VITORIA) || (state_reg == DERROTA) || (state_reg == TOUT);
    assign bus.acertou              = (state_reg == VITORIA);
    assign bus.errou                = (state_reg == DERROTA) || (state_reg == TOUT);
endmodule

// File: tb/tb_controle_jogo_param.sv
// Bench for controle_jogo_param: game-level reference model (round, index,
// lives) driven by randomized plays, plus directed timeout and reset cases.
module tb_controle_jogo_param;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int TO = 8;
    localparam int TI = 3;
    localparam int NV = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    controle_jogo_if #(.ADDR_W(AW)) bus ();

    controle_jogo_param #(
        .N_RODADAS(N), .ADDR_W(AW), .TIMEOUT_CICLOS(TO), .T_INICIAL(TI), .VIDAS(NV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int registra_seen = 0;
    int exp_registra  = 0;
    int grava_addr_q[$];
    int exp_grava_q[$];

    always @(negedge clock) begin
        if (bus.registraR === 1'b1) registra_seen++;
        if (bus.gravaRAM === 1'b1)  grava_addr_q.push_back(int'(bus.endereco));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] code, input string tag);
        int k;
        k = 0;
        while (bus.db_estado !== code && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 32'(bus.db_estado), 32'(code));
    endtask

    task automatic start_game(input logic m);
        int k;
        bus.modo    = m;
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        bus.modo    = 1'($urandom);
        $display("start game modo=%0d", m);
        chk("start_prep", 32'(bus.db_estado), 32'h3);
        k = 0;
        while (bus.exibe_jogada_inicial === 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("exibe_len", 32'(k), 32'(TI));
        chk("after_prep", 32'(bus.db_estado), 32'h2);
    endtask

    // Press a key d cycles into ESPERA; leaves the bench in the cycle after COMPARACAO.
    task automatic press(input logic ok, input int d);
        repeat (d) @(negedge clock);
        bus.jogada         = 1'b1;
        bus.jogada_correta = ok;
        @(negedge clock);
        bus.jogada = 1'b0;
        chk("registra", 32'({bus.db_estado, bus.registraR}), 32'({4'h4, 1'b1}));
        @(negedge clock);
        chk("comparacao", 32'(bus.db_estado), 32'h5);
        exp_registra++;
        @(negedge clock);
        $display("play ok=%0d delay=%0d -> state %0h", ok, d, bus.db_estado);
    endtask

    task automatic play_game(input logic m, input int err_pct, input int to_pct);
        int rnd, idx, lives, k, r, d;
        bit over, sim;
        logic ok;
        logic [3:0] term;
        start_game(m);
        rnd = 0; idx = 0; lives = NV; over = 0; term = 4'hE;
        while (!over) begin
            wait_state(4'h1, "reach_espera");
            chk("esp_endereco", 32'(bus.endereco), 32'(idx));
            chk("esp_rodada", 32'(bus.rodada), 32'(rnd));
            chk("esp_vidas", 32'(bus.vidas_restantes), 32'(lives));
            r = $urandom_range(0, 99);
            if (r < to_pct) begin
                sim = 1'($urandom_range(0, 1));
                k = 0;
                while (bus.db_estado === 4'h1 && k < TO + 4) begin
                    if (sim && k == TO - 1) bus.jogada = 1'b1;
                    @(negedge clock);
                    bus.jogada = 1'b0;
                    k++;
                end
                $display("timeout simultaneous_jogada=%0d after %0d cycles", sim, k);
                chk("timeout_len", 32'(k), 32'(TO));
                chk("timeout_to_perde", 32'(bus.db_estado), 32'hA);
                lives--; idx = 0;
                if (lives == 0) begin term = 4'hB; over = 1; end
            end else begin
                ok = (r < to_pct + err_pct) ? 1'b0 : 1'b1;
                d  = $urandom_range(0, TO - 2);
                press(ok, d);
                if (!ok) begin
                    chk("wrong_to_perde", 32'(bus.db_estado), 32'hA);
                    lives--; idx = 0;
                    if (lives == 0) begin term = 4'hE; over = 1; end
                end else if (idx < rnd) begin
                    chk("prox_jogada", 32'(bus.db_estado), 32'h6);
                    idx++;
                end else begin
                    chk("ultima", 32'(bus.db_estado), 32'h7);
                    if (rnd == N - 1) begin
                        term = 4'hD; over = 1;
                    end else begin
                        rnd++; idx = 0;
                        if (m) begin
                            wait_state(4'h9, "espera_grava");
                            chk("eg_rodada", 32'(bus.rodada), 32'(rnd));
                            repeat ($urandom_range(0, TO - 2)) @(negedge clock);
                            bus.jogada = 1'b1;
                            @(negedge clock);
                            bus.jogada = 1'b0;
                            chk("grava", 32'({bus.db_estado, bus.gravaRAM, bus.endereco}),
                                32'({4'hC, 1'b1, AW'(rnd)}));
                            exp_grava_q.push_back(rnd);
                            @(negedge clock);
                            chk("grava_one_cycle", 32'({bus.db_estado, bus.gravaRAM}), 32'({4'h2, 1'b0}));
                            $display("grava addr=%0d", rnd);
                        end
                    end
                end
            end
        end
        bus.jogada_correta = 1'b0;
        wait_state(term, "terminal");
        $display("game over state=%0h vidas=%0d rodada=%0d", bus.db_estado, bus.vidas_restantes, bus.rodada);
        chk("pronto", 32'(bus.pronto), 32'h1);
        chk("acertou", 32'(bus.acertou), 32'(term == 4'hD));
        chk("errou", 32'(bus.errou), 32'(term != 4'hD));
        chk("final_vidas", 32'(bus.vidas_restantes), 32'(lives));
        if (term == 4'hD) chk("final_rodada", 32'(bus.rodada), 32'(N - 1));
        chk("registra_count", 32'(registra_seen), 32'(exp_registra));
        chk("grava_count", 32'(grava_addr_q.size()), 32'(exp_grava_q.size()));
        while (grava_addr_q.size() > 0 && exp_grava_q.size() > 0)
            chk("grava_addr", 32'(grava_addr_q.pop_front()), 32'(exp_grava_q.pop_front()));
    endtask

    initial begin
        bus.iniciar = 1'b0; bus.jogada = 1'b0; bus.jogada_correta = 1'b0; bus.modo = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_state", 32'(bus.db_estado), 32'h0);
        chk("rst_endereco", 32'(bus.endereco), 32'h0);
        chk("rst_rodada", 32'(bus.rodada), 32'h0);
        chk("rst_vidas", 32'(bus.vidas_restantes), 32'(NV));
        chk("rst_flags", 32'({bus.pronto, bus.acertou, bus.errou, bus.registraR,
                              bus.gravaRAM, bus.exibe_jogada_inicial}), 32'h0);
        reset = 1'b1;
        @(negedge clock);

        play_game(1'b0, 0, 0);
        play_game(1'b1, 0, 0);
        play_game(1'b0, 100, 0);
        play_game(1'b0, 0, 100);

        // Reset in COMPARACAO while endereco=1 must clear everything immediately.
        start_game(1'b0);
        wait_state(4'h1, "rr_espera0");
        press(1'b1, 0);
        wait_state(4'h1, "rr_espera1");
        press(1'b1, 1);
        wait_state(4'h1, "rr_espera2");
        repeat (2) @(negedge clock);
        bus.jogada = 1'b1; bus.jogada_correta = 1'b1;
        @(negedge clock);
        bus.jogada = 1'b0;
        @(negedge clock);
        exp_registra++;
        chk("rr_comparacao", 32'({bus.db_estado, bus.endereco}), 32'({4'h5, AW'(1)}));
        reset = 1'b0;
        #1;
        $display("reset in COMPARACAO -> state %0h", bus.db_estado);
        chk("rr_state", 32'(bus.db_estado), 32'h0);
        chk("rr_endereco", 32'(bus.endereco), 32'h0);
        chk("rr_rodada", 32'(bus.rodada), 32'h0);
        chk("rr_vidas", 32'(bus.vidas_restantes), 32'(NV));
        @(negedge clock);
        reset = 1'b1;
        bus.jogada_correta = 1'b0;
        @(negedge clock);

        for (int g = 0; g < 6; g++)
            play_game(1'($urandom_range(0, 1)), 10, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
